// File: rtl/axi_wr_req_sched_if.sv
// rtl/axi_wr_req_sched_if.sv - AXI4 write channel bundle (AW/W/B) driven by axi_wr_req_sched
// Purpose: groups the AXI4 write address, write data and write response channels.
// Ports (master view):
//   AW: O_AWID[7], O_AWADDR[64], O_AWLEN[8], O_AWSIZE[3], O_AWBURST[2], O_AWVALID, I_AWREADY
//   W : O_WDATA[256], O_WSTRB[32], O_WLAST, O_WVALID, I_WREADY
//   B : I_BID[7], I_BRESP[2], I_BVALID, O_BREADY
interface axi_wr_req_sched_if;
    logic [6:0]   O_AWID;
    logic [63:0]  O_AWADDR;
    logic [7:0]   O_AWLEN;
    logic [2:0]   O_AWSIZE;
    logic [1:0]   O_AWBURST;
    logic         O_AWVALID;
    logic         I_AWREADY;
    logic [255:0] O_WDATA;
    logic [31:0]  O_WSTRB;
    logic         O_WLAST;
    logic         O_WVALID;
    logic         I_WREADY;
    logic [6:0]   I_BID;
    logic [1:0]   I_BRESP;
    logic         I_BVALID;
    logic         O_BREADY;

    modport master (
        output O_AWID, O_AWADDR, O_AWLEN, O_AWSIZE, O_AWBURST, O_AWVALID,
        input  I_AWREADY,
        output O_WDATA, O_WSTRB, O_WLAST, O_WVALID,
        input  I_WREADY,
        input  I_BID, I_BRESP, I_BVALID,
        output O_BREADY
    );

    modport slave (
        input  O_AWID, O_AWADDR, O_AWLEN, O_AWSIZE, O_AWBURST, O_AWVALID,
        output I_AWREADY,
        input  O_WDATA, O_WSTRB, O_WLAST, O_WVALID,
        output I_WREADY,
        output I_BID, I_BRESP, I_BVALID,
        input  O_BREADY
    );
endinterface

// File: rtl/axi_wr_req_sched.sv
// rtl/axi_wr_req_sched.sv - round-robin AXI4 write scheduler for MCTP-over-PCIe-VDM packet sources
// Purpose: grants one of NUM_REQ requesters at a time, issues AW, forwards its beats to W,
//          collects B (with timeout) and keeps a 2-bit packet sequence number per requester.
// Ports:
//   i_clk, i_reset_n                 clock, async active-low reset
//   I_REQ_VALID / O_REQ_READY        request handshake (READY is a one-cycle accept pulse)
//   I_REQ_ADDR / I_REQ_LEN           per-requester address (64b) and AWLEN (8b) slices
//   I_REQ_WDATA / I_REQ_WVALID       per-requester 256b beat stream, O_REQ_WREADY back-pressure
//   O_REQ_DONE / O_REQ_RESP          completion pulse and status
//   O_PKT_SEQ                        2-bit sequence number per requester
//   axi                              AXI4 write master port
module axi_wr_req_sched #(
    parameter int NUM_REQ   = 2,
    parameter int B_TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NUM_REQ-1:0]     I_REQ_VALID,
    output logic [NUM_REQ-1:0]     O_REQ_READY,
    input  logic [NUM_REQ*64-1:0]  I_REQ_ADDR,
    input  logic [NUM_REQ*8-1:0]   I_REQ_LEN,
    input  logic [NUM_REQ*256-1:0] I_REQ_WDATA,
    input  logic [NUM_REQ-1:0]     I_REQ_WVALID,
    output logic [NUM_REQ-1:0]     O_REQ_WREADY,
    output logic [NUM_REQ-1:0]     O_REQ_DONE,
    output logic [1:0]             O_REQ_RESP,
    output logic [NUM_REQ*2-1:0]   O_PKT_SEQ,
    axi_wr_req_sched_if.master     axi
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(B_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            awvalid_q, awvalid_d;
    logic [63:0]     awaddr_q, awaddr_d;
    logic [7:0]      awlen_q, awlen_d;
    logic [6:0]      awid_q, awid_d;
    logic            bready_q, bready_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]      resp_q, resp_d;
    logic [1:0]      seq_q [NUM_REQ];
    logic [1:0]      seq_d [NUM_REQ];

    logic [63:0]     addr_arr  [NUM_REQ];
    logic [7:0]      len_arr   [NUM_REQ];
    logic [255:0]    wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign addr_arr[i]            = I_REQ_ADDR[64*i +: 64];
        assign len_arr[i]             = I_REQ_LEN[8*i +: 8];
        assign wdata_arr[i]           = I_REQ_WDATA[256*i +: 256];
        assign O_PKT_SEQ[2*i +: 2]    = seq_q[i];
    end

    // Round-robin pick: scan from the farthest candidate to the nearest, so the
    // first valid requester after the pointer is the one left standing.
    logic          arb_hit;
    logic [IW-1:0] arb_idx;
    logic [IW-1:0] cand;
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = ptr_q;
        cand    = ptr_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (I_REQ_VALID[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // W channel is a combinational pass-through of the granted requester.
    logic       w_valid;
    logic       w_hs;
    logic [1:0] b_resp;
    assign w_valid = (state_q == ST_DATA) && I_REQ_WVALID[gnt_q];
    assign w_hs    = w_valid && axi.I_WREADY;
    // A response carrying someone else's ID cannot be trusted as ours.
    assign b_resp  = (axi.I_BID != awid_q) ? 2'b10 : axi.I_BRESP;

    always_comb begin
        O_REQ_WREADY = '0;
        if (state_q == ST_DATA) O_REQ_WREADY[gnt_q] = axi.I_WREADY;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awid_d      = awid_q;
        bready_d    = bready_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        req_ready_d = '0;
        done_d      = '0;
        resp_d      = resp_q;
        seq_d       = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    gnt_d                = arb_idx;
                    awaddr_d             = addr_arr[arb_idx];
                    awlen_d              = len_arr[arb_idx];
                    awid_d               = 7'(arb_idx);
                    awvalid_d            = 1'b1;
                    req_ready_d[arb_idx] = 1'b1;
                    state_d              = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.I_AWREADY) begin
                    awvalid_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == awlen_q) begin
                        bready_d = 1'b1;
                        tmo_d    = '0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (axi.I_BVALID && bready_q) begin
                    bready_d      = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    resp_d        = b_resp;
                    if (b_resp == 2'b00) seq_d[gnt_q] = seq_q[gnt_q] + 2'd1;
                    ptr_d         = gnt_q;
                    state_d       = ST_IDLE;
                end else if (tmo_q == TW'(B_TIMEOUT - 1)) begin
                    // Last allowed cycle: complete with SLVERR and stop listening on B.
                    bready_d      = 1'b0;
                    done_d[gnt_q] = 1'b1;
                    resp_d        = 2'b10;
                    ptr_d         = gnt_q;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            gnt_q       <= '0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awid_q      <= '0;
            bready_q    <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            req_ready_q <= '0;
            done_q      <= '0;
            resp_q      <= '0;
            seq_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awid_q      <= awid_d;
            bready_q    <= bready_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            seq_q       <= seq_d;
        end
    end

    assign O_REQ_READY   = req_ready_q;
    assign O_REQ_DONE    = done_q;
    assign O_REQ_RESP    = resp_q;
    assign axi.O_AWID    = awid_q;
    assign axi.O_AWADDR  = awaddr_q;
    assign axi.O_AWLEN   = awlen_q;
    assign axi.O_AWSIZE  = 3'b101;
    assign axi.O_AWBURST = 2'b01;
    assign axi.O_AWVALID = awvalid_q;
    assign axi.O_WDATA   = wdata_arr[gnt_q];
    assign axi.O_WSTRB   = 32'hFFFF_FFFF;
    assign axi.O_WLAST   = (state_q == ST_DATA) && (cnt_q == awlen_q);
    assign axi.O_WVALID  = w_valid;
    assign axi.O_BREADY  = bready_q;
endmodule

// File: tb/tb_axi_wr_req_sched.sv
// tb/tb_axi_wr_req_sched.sv - directed self-checking bench for axi_wr_req_sched
module tb_axi_wr_req_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_wvalid, req_wready, req_done, req_resp;
    logic [3:0]   pkt_seq;
    logic [127:0] req_addr;
    logic [15:0]  req_len;
    logic [511:0] req_wdata;
    int           checks = 0;
    int           failures = 0;

    axi_wr_req_sched_if axi_bus ();

    axi_wr_req_sched #(.NUM_REQ(2), .B_TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .I_REQ_VALID  (req_valid),
        .O_REQ_READY  (req_ready),
        .I_REQ_ADDR   (req_addr),
        .I_REQ_LEN    (req_len),
        .I_REQ_WDATA  (req_wdata),
        .I_REQ_WVALID (req_wvalid),
        .O_REQ_WREADY (req_wready),
        .O_REQ_DONE   (req_done),
        .O_REQ_RESP   (req_resp),
        .O_PKT_SEQ    (pkt_seq),
        .axi          (axi_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] beat(input int r, input int k);
        return {8{32'hD000_0000 + 32'(r * 256 + k)}};
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_wvalid = '0;
        axi_bus.I_BVALID = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // One complete transaction for requester r with AWREADY/WREADY held high.
    task automatic xfer(input int r, input logic [63:0] addr, input int len,
                        input logic [1:0] bresp, input logic [6:0] bid,
                        input logic [1:0] exp_resp, input logic [1:0] exp_seq);
        req_valid[r] = 1'b1;
        req_addr[64*r +: 64] = addr;
        req_len[8*r +: 8] = 8'(len);
        #1;
        chk("aw_valid_pre", 256'(axi_bus.O_AWVALID), 256'(0));
        tick;
        chk("aw_valid", 256'(axi_bus.O_AWVALID), 256'(1));
        chk("aw_id", 256'(axi_bus.O_AWID), 256'(r));
        chk("aw_addr", 256'(axi_bus.O_AWADDR), 256'(addr));
        chk("aw_len", 256'(axi_bus.O_AWLEN), 256'(len));
        chk("req_ready", 256'(req_ready), 256'(1 << r));
        chk("done_quiet", 256'(req_done), 256'(0));
        req_valid[r] = 1'b0;
        axi_bus.I_AWREADY = 1'b1;
        tick;
        chk("aw_valid_drop", 256'(axi_bus.O_AWVALID), 256'(0));
        for (int k = 0; k <= len; k++) begin
            req_wvalid[r] = 1'b1;
            req_wdata[256*r +: 256] = beat(r, k);
            axi_bus.I_WREADY = 1'b1;
            #1;
            chk("w_valid", 256'(axi_bus.O_WVALID), 256'(1));
            chk("w_data", axi_bus.O_WDATA, beat(r, k));
            chk("w_last", 256'(axi_bus.O_WLAST), 256'(k == len));
            chk("req_wready", 256'(req_wready), 256'(1 << r));
            tick;
        end
        req_wvalid[r] = 1'b0;
        chk("b_ready", 256'(axi_bus.O_BREADY), 256'(1));
        chk("done_wait", 256'(req_done), 256'(0));
        axi_bus.I_BVALID = 1'b1;
        axi_bus.I_BRESP = bresp;
        axi_bus.I_BID = bid;
        tick;
        axi_bus.I_BVALID = 1'b0;
        chk("done", 256'(req_done), 256'(1 << r));
        chk("resp", 256'(req_resp), 256'(exp_resp));
        chk("b_ready_drop", 256'(axi_bus.O_BREADY), 256'(0));
        chk("pkt_seq", 256'(pkt_seq[2*r +: 2]), 256'(exp_seq));
    endtask

    initial begin
        int k;
        int cyc;
        logic wv, wr;
        rst_n = 1'b0;
        req_valid = '0;
        req_wvalid = '0;
        req_addr = '0;
        req_len = '0;
        req_wdata = '0;
        axi_bus.I_AWREADY = 1'b0;
        axi_bus.I_WREADY = 1'b0;
        axi_bus.I_BID = '0;
        axi_bus.I_BRESP = '0;
        axi_bus.I_BVALID = 1'b0;
        tick;
        chk("rst_awvalid", 256'(axi_bus.O_AWVALID), 256'(0));
        chk("rst_bready", 256'(axi_bus.O_BREADY), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_done", 256'(req_done), 256'(0));
        chk("rst_resp", 256'(req_resp), 256'(0));
        chk("rst_awaddr", 256'(axi_bus.O_AWADDR), 256'(0));
        chk("rst_awlen", 256'(axi_bus.O_AWLEN), 256'(0));
        chk("rst_awid", 256'(axi_bus.O_AWID), 256'(0));
        chk("rst_seq", 256'(pkt_seq), 256'(0));
        chk("rst_wvalid", 256'(axi_bus.O_WVALID), 256'(0));
        chk("awsize", 256'(axi_bus.O_AWSIZE), 256'(3'b101));
        chk("awburst", 256'(axi_bus.O_AWBURST), 256'(2'b01));
        chk("wstrb", 256'(axi_bus.O_WSTRB), 256'(32'hFFFF_FFFF));
        rst_n = 1'b1;
        tick;

        // Basic 4-beat write from requester 0.
        xfer(0, 64'h1000, 3, 2'b00, 7'd0, 2'b00, 2'd1);
        tick;
        chk("done_pulse_end", 256'(req_done), 256'(0));

        // Both requesters together after reset: 0, 1, then 0, 1 again.
        do_reset;
        req_addr[127:64] = 64'h3000;
        req_len[15:8] = 8'd0;
        req_valid[1] = 1'b1;
        xfer(0, 64'h2000, 0, 2'b00, 7'd0, 2'b00, 2'd1);
        xfer(1, 64'h3000, 0, 2'b00, 7'd1, 2'b00, 2'd1);
        req_valid[1] = 1'b1;
        xfer(0, 64'h2010, 0, 2'b00, 7'd0, 2'b00, 2'd2);
        xfer(1, 64'h3010, 0, 2'b00, 7'd1, 2'b00, 2'd2);

        // AWREADY stall, then gapped WVALID and toggling WREADY on an 8-beat burst.
        axi_bus.I_AWREADY = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[63:0] = 64'h4000_0000_0000_0040;
        req_len[7:0] = 8'd7;
        tick;
        req_valid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_awvalid", 256'(axi_bus.O_AWVALID), 256'(1));
            chk("stall_awaddr", 256'(axi_bus.O_AWADDR), 256'(64'h4000_0000_0000_0040));
            chk("stall_awlen", 256'(axi_bus.O_AWLEN), 256'(7));
            chk("stall_awid", 256'(axi_bus.O_AWID), 256'(0));
            tick;
        end
        axi_bus.I_AWREADY = 1'b1;
        tick;
        chk("stall_aw_done", 256'(axi_bus.O_AWVALID), 256'(0));
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            wv = ((cyc % 3) != 2);
            wr = ((cyc % 2) == 0);
            req_wvalid[0] = wv;
            axi_bus.I_WREADY = wr;
            req_wdata[255:0] = beat(0, k);
            #1;
            chk("gap_wvalid", 256'(axi_bus.O_WVALID), 256'(wv));
            chk("gap_wdata", axi_bus.O_WDATA, beat(0, k));
            chk("gap_wlast", 256'(axi_bus.O_WLAST), 256'(k == 7));
            chk("gap_wready", 256'(req_wready), 256'({1'b0, wr}));
            tick;
            if (wv && wr) k++;
            cyc++;
        end
        chk("gap_beats", 256'(k), 256'(8));
        req_wvalid[0] = 1'b1;
        axi_bus.I_WREADY = 1'b1;
        #1;
        chk("gap_no_extra_beat", 256'(axi_bus.O_WVALID), 256'(0));
        chk("gap_bready", 256'(axi_bus.O_BREADY), 256'(1));
        req_wvalid[0] = 1'b0;
        axi_bus.I_BVALID = 1'b1;
        axi_bus.I_BID = 7'd0;
        axi_bus.I_BRESP = 2'b00;
        tick;
        axi_bus.I_BVALID = 1'b0;
        chk("gap_done", 256'(req_done), 256'(1));
        chk("gap_seq", 256'(pkt_seq[1:0]), 256'(3));
        tick;

        // Error responses leave the sequence number alone.
        xfer(1, 64'h7000, 0, 2'b10, 7'd1, 2'b10, 2'd2);
        xfer(1, 64'h7100, 0, 2'b00, 7'd5, 2'b10, 2'd2);
        do_reset;
        chk("seq_after_reset", 256'(pkt_seq), 256'(0));
        for (int i = 0; i < 4; i++)
            xfer(0, 64'h8000 + 64'(i * 64), 1, 2'b00, 7'd0, 2'b00, 2'((i + 1) % 4));

        // B timeout with requester 1 waiting.
        req_valid[0] = 1'b1;
        req_addr[63:0] = 64'h9000;
        req_len[7:0] = 8'd0;
        tick;
        req_valid[0] = 1'b0;
        axi_bus.I_AWREADY = 1'b1;
        tick;
        req_wvalid[0] = 1'b1;
        req_wdata[255:0] = beat(0, 0);
        axi_bus.I_WREADY = 1'b1;
        tick;
        req_wvalid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_addr[127:64] = 64'hA000;
        req_len[15:8] = 8'd0;
        chk("tmo_bready_rise", 256'(axi_bus.O_BREADY), 256'(1));
        for (int c = 1; c < 16; c++) begin
            tick;
            chk("tmo_bready_hold", 256'(axi_bus.O_BREADY), 256'(1));
            chk("tmo_no_done", 256'(req_done), 256'(0));
            chk("tmo_req1_waits", 256'(axi_bus.O_AWVALID), 256'(0));
        end
        tick;
        chk("tmo_done", 256'(req_done), 256'(1));
        chk("tmo_resp", 256'(req_resp), 256'(2'b10));
        chk("tmo_bready_drop", 256'(axi_bus.O_BREADY), 256'(0));
        chk("tmo_seq", 256'(pkt_seq[1:0]), 256'(0));
        axi_bus.I_BVALID = 1'b1;
        axi_bus.I_BID = 7'd0;
        axi_bus.I_BRESP = 2'b00;
        xfer(1, 64'hA000, 0, 2'b00, 7'd1, 2'b00, 2'd1);
        tick;

        // Asynchronous reset in the middle of DATA.
        req_valid[0] = 1'b1;
        req_addr[63:0] = 64'h5000;
        req_len[7:0] = 8'd3;
        tick;
        req_valid[0] = 1'b0;
        axi_bus.I_AWREADY = 1'b1;
        tick;
        for (int b = 0; b < 2; b++) begin
            req_wvalid[0] = 1'b1;
            req_wdata[255:0] = beat(0, b);
            axi_bus.I_WREADY = 1'b1;
            tick;
        end
        req_wdata[255:0] = beat(0, 2);
        #1;
        chk("arst_pre_wvalid", 256'(axi_bus.O_WVALID), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_awvalid", 256'(axi_bus.O_AWVALID), 256'(0));
        chk("arst_bready", 256'(axi_bus.O_BREADY), 256'(0));
        chk("arst_wvalid", 256'(axi_bus.O_WVALID), 256'(0));
        chk("arst_wready", 256'(req_wready), 256'(0));
        chk("arst_awaddr", 256'(axi_bus.O_AWADDR), 256'(0));
        chk("arst_awlen", 256'(axi_bus.O_AWLEN), 256'(0));
        chk("arst_seq", 256'(pkt_seq), 256'(0));
        chk("arst_done", 256'(req_done), 256'(0));
        tick;
        req_wvalid[0] = 1'b0;
        rst_n = 1'b1;
        tick;
        xfer(0, 64'h6000, 1, 2'b00, 7'd0, 2'b00, 2'd1);
        chk("arst_seq_final", 256'(pkt_seq), 256'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
